// File: rtl/axi_arbiter_pkg.sv
// Shared types and bus widths for the two-master AXI-lite arbiter in front of xbar.
package arb_pkg;

  localparam int AXI_ADDR_BUS  = 32;
  localparam int AXI_DATA_BUS  = 32;
  localparam int AXI_RESP_BUS  = 2;
  localparam int AXI_WSTRB_BUS = 4;

  typedef enum logic [1:0] {
    IDLE,
    GNT_M0_RD,
    GNT_M1_RD,
    GNT_M1_WR
  } arb_state_t;

  // Encodings held in last_gnt: which master completed the most recent grant.
  localparam logic MST_M0 = 1'b0;
  localparam logic MST_M1 = 1'b1;

endpackage

// File: rtl/axi_arbiter_if.sv
// AXI-lite bundle; master drives requests, slave answers. rd_slave is the read-only view used for the IFU.
interface axi_arbiter_if;
  import arb_pkg::*;

  logic [AXI_ADDR_BUS-1:0]  araddr;
  logic                     arvalid;
  logic                     arready;
  logic [AXI_DATA_BUS-1:0]  rdata;
  logic [AXI_RESP_BUS-1:0]  rresp;
  logic                     rvalid;
  logic                     rready;
  logic [AXI_ADDR_BUS-1:0]  awaddr;
  logic                     awvalid;
  logic                     awready;
  logic [AXI_DATA_BUS-1:0]  wdata;
  logic [AXI_WSTRB_BUS-1:0] wstrb;
  logic                     wvalid;
  logic                     wready;
  logic [AXI_RESP_BUS-1:0]  bresp;
  logic                     bvalid;
  logic                     bready;

  modport master (
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

  modport slave (
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

  modport rd_slave (
    input  araddr, arvalid, rready,
    output arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/axi_arbiter.sv
// Round-robin arbiter sharing the xbar AXI-lite master port between IFU (m0, read-only) and LSU (m1).
// One whole transaction is granted at a time; channels are wired combinationally, nothing is buffered.
module axi_arbiter
  import arb_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  axi_arbiter_if.rd_slave m0,
  axi_arbiter_if.slave    m1,
  axi_arbiter_if.master   arbiter_xbar
);

  arb_state_t state_q, state_d;
  logic       last_gnt_q, last_gnt_d;
  logic       req0, req1, m1_wr_pend;

  assign req0       = m0.arvalid;
  assign m1_wr_pend = m1.awvalid | m1.wvalid;
  assign req1       = m1.arvalid | m1_wr_pend;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      last_gnt_q <= MST_M1;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    unique case (state_q)
      IDLE: begin
        // m1 wins when alone or when m0 owned the last completed grant
        if (req1 && (!req0 || last_gnt_q == MST_M0)) begin
          state_d = m1_wr_pend ? GNT_M1_WR : GNT_M1_RD;
        end else if (req0) begin
          state_d = GNT_M0_RD;
        end
      end
      GNT_M0_RD: begin
        if (arbiter_xbar.rvalid && m0.rready) begin
          state_d    = IDLE;
          last_gnt_d = MST_M0;
        end
      end
      GNT_M1_RD: begin
        if (arbiter_xbar.rvalid && m1.rready) begin
          state_d    = IDLE;
          last_gnt_d = MST_M1;
        end
      end
      GNT_M1_WR: begin
        if (arbiter_xbar.bvalid && m1.bready) begin
          state_d    = IDLE;
          last_gnt_d = MST_M1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    arbiter_xbar.araddr  = '0;
    arbiter_xbar.arvalid = 1'b0;
    arbiter_xbar.rready  = 1'b0;
    arbiter_xbar.awaddr  = '0;
    arbiter_xbar.awvalid = 1'b0;
    arbiter_xbar.wdata   = '0;
    arbiter_xbar.wstrb   = '0;
    arbiter_xbar.wvalid  = 1'b0;
    arbiter_xbar.bready  = 1'b0;
    m0.arready = 1'b0;
    m0.rdata   = '0;
    m0.rresp   = '0;
    m0.rvalid  = 1'b0;
    m1.arready = 1'b0;
    m1.rdata   = '0;
    m1.rresp   = '0;
    m1.rvalid  = 1'b0;
    m1.awready = 1'b0;
    m1.wready  = 1'b0;
    m1.bresp   = '0;
    m1.bvalid  = 1'b0;
    unique case (state_q)
      GNT_M0_RD: begin
        arbiter_xbar.araddr  = m0.araddr;
        arbiter_xbar.arvalid = m0.arvalid;
        arbiter_xbar.rready  = m0.rready;
        m0.arready = arbiter_xbar.arready;
        m0.rdata   = arbiter_xbar.rdata;
        m0.rresp   = arbiter_xbar.rresp;
        m0.rvalid  = arbiter_xbar.rvalid;
      end
      GNT_M1_RD: begin
        arbiter_xbar.araddr  = m1.araddr;
        arbiter_xbar.arvalid = m1.arvalid;
        arbiter_xbar.rready  = m1.rready;
        m1.arready = arbiter_xbar.arready;
        m1.rdata   = arbiter_xbar.rdata;
        m1.rresp   = arbiter_xbar.rresp;
        m1.rvalid  = arbiter_xbar.rvalid;
      end
      GNT_M1_WR: begin
        arbiter_xbar.awaddr  = m1.awaddr;
        arbiter_xbar.awvalid = m1.awvalid;
        arbiter_xbar.wdata   = m1.wdata;
        arbiter_xbar.wstrb   = m1.wstrb;
        arbiter_xbar.wvalid  = m1.wvalid;
        arbiter_xbar.bready  = m1.bready;
        m1.awready = arbiter_xbar.awready;
        m1.wready  = arbiter_xbar.wready;
        m1.bresp   = arbiter_xbar.bresp;
        m1.bvalid  = arbiter_xbar.bvalid;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_axi_arbiter.sv
// Bench for axi_arbiter: reactive IFU/LSU masters and xbar slave, an ownership model checked every cycle,
// and directed scenarios with literal expectations.
module tb_axi_arbiter;
  import arb_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi_arbiter_if m0_if ();
  axi_arbiter_if m1_if ();
  axi_arbiter_if xb_if ();

  axi_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .m0           (m0_if),
    .m1           (m1_if),
    .arbiter_xbar (xb_if)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- ownership model ----------------
  localparam int O_NONE = 0, O_M0R = 1, O_M1R = 2, O_M1W = 3;
  int owner;
  int last_m;   // master (0/1) that finished the last transaction

  function automatic int pick(input logic r0, input logic r1, input logic wr1, input int last);
    if (!r0 && !r1) return O_NONE;
    if (r0 && (!r1 || last == 1)) return O_M0R;
    return wr1 ? O_M1W : O_M1R;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner  <= O_NONE;
      last_m <= 1;
    end else begin
      case (owner)
        O_NONE: owner <= pick(m0_if.arvalid, m1_if.arvalid | m1_if.awvalid | m1_if.wvalid,
                              m1_if.awvalid | m1_if.wvalid, last_m);
        O_M0R: if (xb_if.rvalid && m0_if.rready) begin owner <= O_NONE; last_m <= 0; end
        O_M1R: if (xb_if.rvalid && m1_if.rready) begin owner <= O_NONE; last_m <= 1; end
        O_M1W: if (xb_if.bvalid && m1_if.bready) begin owner <= O_NONE; last_m <= 1; end
        default: owner <= O_NONE;
      endcase
    end
  end

  typedef struct packed {
    logic [31:0] araddr; logic arvalid; logic rready;
    logic [31:0] awaddr; logic awvalid; logic [31:0] wdata; logic [3:0] wstrb; logic wvalid; logic bready;
  } xo_t;
  typedef struct packed {
    logic arready; logic [31:0] rdata; logic [1:0] rresp; logic rvalid;
    logic awready; logic wready; logic [1:0] bresp; logic bvalid;
  } mo_t;

  task automatic compare_cycle();
    xo_t ex_x, ac_x;
    mo_t ex0, ac0, ex1, ac1;
    ex_x = '0; ex0 = '0; ex1 = '0;
    ac_x = '{xb_if.araddr, xb_if.arvalid, xb_if.rready, xb_if.awaddr, xb_if.awvalid,
             xb_if.wdata, xb_if.wstrb, xb_if.wvalid, xb_if.bready};
    ac0 = '{m0_if.arready, m0_if.rdata, m0_if.rresp, m0_if.rvalid, 1'b0, 1'b0, 2'b0, 1'b0};
    ac1 = '{m1_if.arready, m1_if.rdata, m1_if.rresp, m1_if.rvalid,
            m1_if.awready, m1_if.wready, m1_if.bresp, m1_if.bvalid};
    if (owner == O_M0R || owner == O_M1R) begin
      ex_x.araddr  = (owner == O_M0R) ? m0_if.araddr  : m1_if.araddr;
      ex_x.arvalid = (owner == O_M0R) ? m0_if.arvalid : m1_if.arvalid;
      ex_x.rready  = (owner == O_M0R) ? m0_if.rready  : m1_if.rready;
      ex1.arready = xb_if.arready; ex1.rdata = xb_if.rdata;
      ex1.rresp = xb_if.rresp; ex1.rvalid = xb_if.rvalid;
      if (owner == O_M0R) begin ex0 = ex1; ex1 = '0; end
    end else if (owner == O_M1W) begin
      ex_x.awaddr = m1_if.awaddr; ex_x.awvalid = m1_if.awvalid; ex_x.wdata = m1_if.wdata;
      ex_x.wstrb = m1_if.wstrb; ex_x.wvalid = m1_if.wvalid; ex_x.bready = m1_if.bready;
      ex1.awready = xb_if.awready; ex1.wready = xb_if.wready;
      ex1.bresp = xb_if.bresp; ex1.bvalid = xb_if.bvalid;
    end
    check("xbar_outputs", ac_x, ex_x);
    check("m0_outputs", ac0, ex0);
    check("m1_outputs", ac1, ex1);
  endtask

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      compare_cycle();
    end
  end

  // ---------------- reactive masters and slave ----------------
  int          cyc = 0;
  int          rd_lat = 1, rd_cnt = 0;
  bit          rd_pend, aw_got, w_got, sl_wready_en = 1'b1;
  logic [31:0] sl_rdata, sl_araddr, sl_awaddr, sl_wdata;
  logic [3:0]  sl_wstrb;
  int          m0_left;
  logic [31:0] m0_next_addr, m0_got, m1_rdata_got;
  logic [1:0]  m1_bresp_got;
  int          log_q[$];
  int          log_cyc[$];
  bit          s_xarvalid, s_xwvalid, s_xawvalid;
  logic [31:0] s_xaraddr;
  int          m1_fwd_cyc;
  bit          track_m1;
  int          m1_ar_viol;

  task automatic tick();
    bit h_ar0, h_r0, h_ar1, h_r1, h_aw1, h_w1, h_b1, h_xar, h_xr, h_xaw, h_xw, h_xb;
    @(negedge clk);
    h_ar0 = m0_if.arvalid & m0_if.arready;
    h_r0  = m0_if.rvalid  & m0_if.rready;
    h_ar1 = m1_if.arvalid & m1_if.arready;
    h_r1  = m1_if.rvalid  & m1_if.rready;
    h_aw1 = m1_if.awvalid & m1_if.awready;
    h_w1  = m1_if.wvalid  & m1_if.wready;
    h_b1  = m1_if.bvalid  & m1_if.bready;
    h_xar = xb_if.arvalid & xb_if.arready;
    h_xr  = xb_if.rvalid  & xb_if.rready;
    h_xaw = xb_if.awvalid & xb_if.awready;
    h_xw  = xb_if.wvalid  & xb_if.wready;
    h_xb  = xb_if.bvalid  & xb_if.bready;
    s_xarvalid = xb_if.arvalid; s_xaraddr = xb_if.araddr;
    s_xwvalid  = xb_if.wvalid;  s_xawvalid = xb_if.awvalid;
    if (track_m1 && m1_if.arready) m1_ar_viol++;
    if (s_xarvalid && s_xaraddr == 32'h0000_0500 && m1_fwd_cyc < 0) m1_fwd_cyc = cyc;
    if (h_r0) begin m0_got = m0_if.rdata; log_q.push_back(0); log_cyc.push_back(cyc); track_m1 = 1'b0; end
    if (h_r1) begin m1_rdata_got = m1_if.rdata; log_q.push_back(1); log_cyc.push_back(cyc); end
    if (h_b1) begin m1_bresp_got = m1_if.bresp; log_q.push_back(2); log_cyc.push_back(cyc); end
    if (h_xar) sl_araddr = xb_if.araddr;
    if (h_xaw) sl_awaddr = xb_if.awaddr;
    if (h_xw) begin sl_wdata = xb_if.wdata; sl_wstrb = xb_if.wstrb; end
    @(posedge clk);
    #1;
    cyc++;
    if (h_ar0) m0_if.arvalid = 1'b0;
    if (h_r0 && m0_left > 0) begin
      m0_if.arvalid = 1'b1; m0_if.araddr = m0_next_addr; m0_left--;
    end
    if (h_ar1) m1_if.arvalid = 1'b0;
    if (h_aw1) m1_if.awvalid = 1'b0;
    if (h_w1)  m1_if.wvalid  = 1'b0;
    if (h_xar) begin rd_pend = 1'b1; rd_cnt = rd_lat; end
    if (h_xr) begin xb_if.rvalid = 1'b0; xb_if.rdata = '0; end
    if (rd_pend) begin
      if (rd_cnt <= 1) begin xb_if.rvalid = 1'b1; xb_if.rdata = sl_rdata; rd_pend = 1'b0; end
      else rd_cnt--;
    end
    if (h_xaw) aw_got = 1'b1;
    if (h_xw)  w_got  = 1'b1;
    if (h_xb)  xb_if.bvalid = 1'b0;
    if (aw_got && w_got) begin xb_if.bvalid = 1'b1; xb_if.bresp = 2'b00; aw_got = 1'b0; w_got = 1'b0; end
    xb_if.wready = sl_wready_en;
  endtask

  task automatic clear_drives();
    m0_if.araddr = '0; m0_if.arvalid = 1'b0; m0_if.rready = 1'b1;
    m1_if.araddr = '0; m1_if.arvalid = 1'b0; m1_if.rready = 1'b1;
    m1_if.awaddr = '0; m1_if.awvalid = 1'b0; m1_if.wdata = '0; m1_if.wstrb = '0;
    m1_if.wvalid = 1'b0; m1_if.bready = 1'b1;
    xb_if.arready = 1'b1; xb_if.rdata = '0; xb_if.rresp = '0; xb_if.rvalid = 1'b0;
    xb_if.awready = 1'b1; xb_if.wready = 1'b1; xb_if.bresp = '0; xb_if.bvalid = 1'b0;
    rd_pend = 1'b0; aw_got = 1'b0; w_got = 1'b0; sl_wready_en = 1'b1; m0_left = 0;
    track_m1 = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    clear_drives();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    log_q.delete(); log_cyc.delete();
  endtask

  task automatic wait_log(input string name, input int n, input int budget);
    int b = 0;
    while (log_q.size() < n && b < budget) begin tick(); b++; end
    check(name, log_q.size() >= n, 1'b1);
  endtask

  initial begin
    clear_drives();
    #1;
    check("reset_xbar_arvalid", xb_if.arvalid, 1'b0);
    check("reset_m1_bvalid", m1_if.bvalid, 1'b0);
    apply_reset();

    // m0 alone, slave answers 3 cycles after AR
    sl_rdata = 32'h1234_5678; rd_lat = 3;
    m0_if.araddr = 32'h8000_0000; m0_if.arvalid = 1'b1;
    tick(); check("lat_idle_cycle", s_xarvalid, 1'b0);
    tick(); check("lat_forwarded", s_xarvalid, 1'b1);
    wait_log("m0_read_done", 1, 20);
    repeat (3) tick();
    check("m0_rdata", m0_got, 32'h1234_5678);
    check("m0_slave_addr", sl_araddr, 32'h8000_0000);
    check("m0_only_one_txn", log_q.size(), 1);

    // tie straight after reset: m0, m1, then m0 again after a second tie
    apply_reset();
    rd_lat = 1; sl_rdata = 32'hcafe_0001;
    m0_if.araddr = 32'h100; m0_if.arvalid = 1'b1; m0_left = 1; m0_next_addr = 32'h104;
    m1_if.araddr = 32'h200; m1_if.arvalid = 1'b1;
    wait_log("tie_done", 3, 60);
    check("tie_first", log_q[0], 0);
    check("tie_second", log_q[1], 1);
    check("tie_third", log_q[2], 0);

    // m1 read and write together: write first
    log_q.delete(); log_cyc.delete();
    sl_rdata = 32'hbeef_0002;
    m1_if.araddr = 32'h300; m1_if.arvalid = 1'b1;
    m1_if.awaddr = 32'ha000_03f8; m1_if.awvalid = 1'b1;
    m1_if.wdata = 32'h41; m1_if.wstrb = 4'h1; m1_if.wvalid = 1'b1;
    wait_log("rw_done", 2, 40);
    check("rw_first_is_write", log_q[0], 2);
    check("rw_second_is_read", log_q[1], 1);
    check("rw_bresp", m1_bresp_got, 2'b00);
    check("rw_awaddr", sl_awaddr, 32'ha000_03f8);
    check("rw_wdata", sl_wdata, 32'h41);
    check("rw_wstrb", sl_wstrb, 4'h1);
    check("rw_rdata", m1_rdata_got, 32'hbeef_0002);

    // W leads AW by 2 cycles
    log_q.delete(); log_cyc.delete();
    m1_if.wdata = 32'h55; m1_if.wstrb = 4'hf; m1_if.wvalid = 1'b1;
    repeat (2) tick();
    m1_if.awaddr = 32'h10; m1_if.awvalid = 1'b1;
    wait_log("skew_done", 1, 20);
    tick();
    check("skew_idle_after_b", s_xawvalid | s_xwvalid, 1'b0);
    repeat (3) tick();
    check("skew_single_b", log_q.size(), 1);
    check("skew_wdata", sl_wdata, 32'h55);

    // reset while GNT_M1_WR holds an unaccepted W
    log_q.delete(); log_cyc.delete();
    sl_wready_en = 1'b0;
    m1_if.awaddr = 32'h20; m1_if.awvalid = 1'b1;
    m1_if.wdata = 32'h77; m1_if.wstrb = 4'h3; m1_if.wvalid = 1'b1;
    repeat (3) tick();
    check("rst_pre_wvalid", s_xwvalid, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rst_xbar_zero", {xb_if.awvalid, xb_if.wvalid, xb_if.wdata, xb_if.bready}, '0);
    check("rst_m1_zero", {m1_if.awready, m1_if.wready, m1_if.bvalid, m1_if.arready}, '0);
    apply_reset();
    repeat (2) tick();
    check("rst_idle_after", s_xawvalid | s_xwvalid | s_xarvalid, 1'b0);
    check("rst_no_b", log_q.size(), 0);

    // rvalid held off 10 cycles while m1 waits
    rd_lat = 10; sl_rdata = 32'h0bad_f00d; m1_fwd_cyc = -1; m1_ar_viol = 0;
    m0_if.araddr = 32'h400; m0_if.arvalid = 1'b1;
    m1_if.araddr = 32'h500; m1_if.arvalid = 1'b1;
    track_m1 = 1'b1;
    wait_log("hold_done", 2, 60);
    check("hold_order_m0", log_q[0], 0);
    check("hold_m1_arready_low", m1_ar_viol, 0);
    check("hold_m0_rdata", m0_got, 32'h0bad_f00d);
    check("hold_m1_grant_gap", m1_fwd_cyc - log_cyc[0], 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
